// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_pkg
//  Purpose  : Shared funct encodings, operation/state enums and decode helpers
//             for the iterative shift unit.
//  Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

    // Instruction funct field encodings for the supported shift operations
    localparam logic [5:0] c_FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] c_FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] c_FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] c_FUNCT_SLLV = 6'b000100;
    localparam logic [5:0] c_FUNCT_SRLV = 6'b000110;
    localparam logic [5:0] c_FUNCT_SRAV = 6'b000111;

    // Decoded operation
    typedef enum logic [2:0] {
        SLL     = 3'd0,
        SRL     = 3'd1,
        SRA     = 3'd2,
        SLLV    = 3'd3,
        SRLV    = 3'd4,
        SRAV    = 3'd5,
        ILLEGAL = 3'd6
    } op_e;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Map a funct field onto an operation; anything unknown is ILLEGAL
    function automatic op_e decode_funct(input logic [5:0] funct);
        op_e op;
        case (funct)
            c_FUNCT_SLL:  op = SLL;
            c_FUNCT_SRL:  op = SRL;
            c_FUNCT_SRA:  op = SRA;
            c_FUNCT_SLLV: op = SLLV;
            c_FUNCT_SRLV: op = SRLV;
            c_FUNCT_SRAV: op = SRAV;
            default:      op = ILLEGAL;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_amount_sel.sv
`default_nettype none
// ============================================================================
//  Module   : shift_amount_sel
//  Purpose  : Picks the effective shift amount: the immediate for the
//             immediate forms, the register value (clamped to WIDTH-1 when it
//             is out of range) for the variable forms.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_amount_sel
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  op_e              i_op,
    input  logic [SHW-1:0]   i_shamt_imm,
    input  logic [WIDTH-1:0] i_reg_amt,
    output logic [SHW-1:0]   o_amt
);

    // Any set bit above the amount field means the register value is >= WIDTH
    logic w_reg_over;
    assign w_reg_over = |i_reg_amt[WIDTH-1:SHW];

    // Amount mux; WIDTH is a power of two so all-ones equals WIDTH-1
    always_comb begin
        o_amt = '0;
        case (i_op)
            SLL, SRL, SRA:    o_amt = i_shamt_imm;
            SLLV, SRLV, SRAV: o_amt = w_reg_over ? {SHW{1'b1}} : i_reg_amt[SHW-1:0];
            default:          o_amt = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/iterative_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : iterative_shift_unit
//  Purpose  : Multi-cycle shifter for SLL/SRL/SRA and their variable forms.
//             Shifts at most STEP bit positions per cycle, pulses done for one
//             cycle with the result, and holds the result until the next done.
//  Revision : 1.0 - initial release
// ============================================================================
module iterative_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [SHW-1:0]   shamt_imm,
    input  logic [WIDTH-1:0] reg_amt,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    // Remaining count is one bit wider so STEP == WIDTH is representable
    localparam logic [SHW:0] c_STEP = (SHW+1)'(STEP);

    state_e           r_state;
    op_e              r_op;
    logic [WIDTH-1:0] r_work;
    logic [SHW:0]     r_remaining;
    logic             r_fill;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_illegal;

    op_e              w_op;
    logic [SHW-1:0]   w_amt;
    logic [SHW:0]     w_step;
    logic [SHW:0]     w_rem_next;
    logic [WIDTH-1:0] w_fill_mask;
    logic [WIDTH-1:0] w_work_next;

    assign w_op = decode_funct(funct);

    shift_amount_sel #(
        .WIDTH (WIDTH)
    ) u_amount_sel (
        .i_op        (w_op),
        .i_shamt_imm (shamt_imm),
        .i_reg_amt   (reg_amt),
        .o_amt       (w_amt)
    );

    // Bits moved this cycle: min(STEP, remaining)
    assign w_step      = (r_remaining < c_STEP) ? r_remaining : c_STEP;
    assign w_rem_next  = r_remaining - w_step;
    // Ones in the top w_step positions, used for arithmetic sign fill
    assign w_fill_mask = ~({WIDTH{1'b1}} >> w_step);

    // One shift step of the working register according to the captured op
    always_comb begin
        w_work_next = r_work;
        case (r_op)
            SLL, SLLV: w_work_next = r_work << w_step;
            SRL, SRLV: w_work_next = r_work >> w_step;
            SRA, SRAV: w_work_next = (r_work >> w_step) | (r_fill ? w_fill_mask : '0);
            default:   w_work_next = r_work;
        endcase
    end

    // Control FSM and datapath registers; outputs are registered alongside state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_op        <= SLL;
            r_work      <= '0;
            r_remaining <= '0;
            r_fill      <= 1'b0;
            r_result    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    // start is ignored while shifting
                    r_work      <= w_work_next;
                    r_remaining <= w_rem_next;
                    if (w_rem_next == '0) begin
                        r_state  <= ST_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_work_next;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request
                    r_done    <= 1'b0;
                    r_illegal <= 1'b0;
                    if (start) begin
                        r_op        <= w_op;
                        r_work      <= operand;
                        r_fill      <= operand[WIDTH-1];
                        r_remaining <= {1'b0, w_amt};
                        if ((w_op == ILLEGAL) || (w_amt == '0)) begin
                            // Nothing to shift: finish immediately with operand
                            r_state     <= ST_DONE;
                            r_done      <= 1'b1;
                            r_illegal   <= (w_op == ILLEGAL);
                            r_result    <= operand;
                            r_remaining <= '0;
                        end else begin
                            r_state <= ST_SHIFT;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;
    assign illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_iterative_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iterative_shift_unit
//  Purpose  : Self-checking bench: two instances (STEP=1 and STEP=4) share the
//             stimulus; a transaction-level model predicts busy/done/illegal/
//             result per cycle, and directed cases pin literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iterative_shift_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [4:0]  shamt_imm;
    logic [31:0] reg_amt;
    logic [31:0] operand;

    logic [1:0]  busy_v;
    logic [1:0]  done_v;
    logic [1:0]  ill_v;
    logic [31:0] res_v [2];

    int n_vec = 0;
    int n_err = 0;

    iterative_shift_unit #(.WIDTH(32), .STEP(1)) u_dut_s1 (
        .clk(clk), .reset(reset), .start(start), .funct(funct),
        .shamt_imm(shamt_imm), .reg_amt(reg_amt), .operand(operand),
        .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]), .illegal(ill_v[0])
    );

    iterative_shift_unit #(.WIDTH(32), .STEP(4)) u_dut_s4 (
        .clk(clk), .reset(reset), .start(start), .funct(funct),
        .shamt_imm(shamt_imm), .reg_amt(reg_amt), .operand(operand),
        .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]), .illegal(ill_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int step_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Reference behaviour of one instruction: effective amount and result
    function automatic void ref_op(input logic [5:0] f, input logic [4:0] sh,
                                   input logic [31:0] ra, input logic [31:0] op,
                                   output logic [31:0] r, output logic ill, output int amt);
        int ramt;
        if (ra < 32) ramt = int'(ra);
        else         ramt = 31;
        ill = 1'b0;
        amt = 0;
        r   = op;
        case (f)
            6'b000000: begin amt = int'(sh); r = op << amt; end
            6'b000010: begin amt = int'(sh); r = op >> amt; end
            6'b000011: begin amt = int'(sh); r = 32'($signed(op) >>> amt); end
            6'b000100: begin amt = ramt;     r = op << amt; end
            6'b000110: begin amt = ramt;     r = op >> amt; end
            6'b000111: begin amt = ramt;     r = 32'($signed(op) >>> amt); end
            default:   begin ill = 1'b1;     r = op; end
        endcase
    endfunction

    // ---------------- transaction-level model ----------------
    int          cyc = 0;
    logic        e_busy [2];
    logic        e_done [2];
    logic        e_ill  [2];
    logic [31:0] e_res  [2];
    logic        pend   [2];
    int          done_at[2];
    logic [31:0] p_res  [2];
    logic        p_ill  [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            e_busy[d] = 0; e_done[d] = 0; e_ill[d] = 0; e_res[d] = 0;
            pend[d] = 0; done_at[d] = 0; p_res[d] = 0; p_ill[d] = 0;
        end
    end

    // Expected outputs for the cycle following each rising edge
    always @(posedge clk) begin
        logic [31:0] r;
        logic        ill;
        int          amt;
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                e_busy[d] = 0; e_done[d] = 0; e_ill[d] = 0; e_res[d] = 0; pend[d] = 0;
            end else begin
                if (start && !e_busy[d]) begin
                    ref_op(funct, shamt_imm, reg_amt, operand, r, ill, amt);
                    pend[d]    = 1;
                    p_res[d]   = r;
                    p_ill[d]   = ill;
                    done_at[d] = cyc + (amt + step_of(d) - 1) / step_of(d);
                end
                e_busy[d] = pend[d] && (cyc < done_at[d]);
                e_done[d] = pend[d] && (cyc == done_at[d]);
                e_ill[d]  = e_done[d] && p_ill[d];
                if (e_done[d]) begin
                    e_res[d] = p_res[d];
                    pend[d]  = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                chk($sformatf("busy[%0d]", d),    busy_v[d], 0);
                chk($sformatf("done[%0d]", d),    done_v[d], 0);
                chk($sformatf("illegal[%0d]", d), ill_v[d],  0);
                chk($sformatf("result[%0d]", d),  res_v[d],  0);
            end else begin
                chk($sformatf("busy[%0d]", d),    busy_v[d], e_busy[d]);
                chk($sformatf("done[%0d]", d),    done_v[d], e_done[d]);
                chk($sformatf("illegal[%0d]", d), ill_v[d],  e_ill[d]);
                chk($sformatf("result[%0d]", d),  res_v[d],  e_res[d]);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_done(input int d, output int lat, output bit saw_busy);
        lat = 0;
        saw_busy = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (busy_v[d]) saw_busy = 1;
            if (done_v[d]) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (busy_v == 2'b00) break;
            @(negedge clk);
            #1;
        end
        chk("idle_timeout", busy_v, 2'b00);
    endtask

    task automatic directed(input string nm, input logic [5:0] f, input logic [4:0] sh,
                            input logic [31:0] ra, input logic [31:0] op, input int d,
                            input int exp_lat, input logic [31:0] exp_res,
                            input logic exp_ill, input logic exp_busy_seen);
        int lat;
        bit sb;
        funct = f; shamt_imm = sh; reg_amt = ra; operand = op; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(d, lat, sb);
        chk({nm, "_latency"},   lat,       exp_lat);
        chk({nm, "_result"},    res_v[d],  exp_res);
        chk({nm, "_illegal"},   ill_v[d],  exp_ill);
        chk({nm, "_busy_seen"}, sb,        exp_busy_seen);
        #1;
        wait_idle();
    endtask

    logic [5:0] legal_f [6] = '{6'b000000, 6'b000010, 6'b000011,
                                6'b000100, 6'b000110, 6'b000111};
    logic [5:0] bad_f   [4] = '{6'b000001, 6'b100000, 6'b000101, 6'b111111};

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        bit sb;
        bit found;
        int dcount;

        reset = 1'b0; start = 1'b0; funct = '0; shamt_imm = '0; reg_amt = '0; operand = '0;
        repeat (2) @(negedge clk);
        chk("reset_result0", res_v[0], 32'h0);
        chk("reset_busy",    busy_v,   2'b00);
        #1 reset = 1'b1;

        // SLL imm 4, STEP=1: five cycles to done
        directed("sll_imm4", 6'b000000, 5'd4, 32'h0, 32'h00000001, 0, 5, 32'h00000010, 1'b0, 1'b1);
        // SRAV with out-of-range amount clamps to 31; STEP=4 takes nine cycles
        directed("srav_clamp", 6'b000111, 5'd0, 32'h00000100, 32'h80000000, 1, 9, 32'hFFFFFFFF, 1'b0, 1'b1);
        // Zero amount finishes next cycle without ever being busy
        directed("srl_zero", 6'b000010, 5'd0, 32'h0, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 1'b0, 1'b0);
        // Unsupported funct passes operand through and flags illegal
        directed("illegal", 6'b100000, 5'd3, 32'h5, 32'h12345678, 1, 1, 32'h12345678, 1'b1, 1'b0);

        // SLLV by 8 with junk requests during the shift, then a back-to-back start
        funct = 6'b000100; reg_amt = 32'd8; operand = 32'h000000AB; shamt_imm = 5'd0; start = 1'b1;
        @(posedge clk);
        #1;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            start = 1'b1; funct = 6'b000010; shamt_imm = 5'd3;
            operand = $urandom; reg_amt = $urandom;
            @(negedge clk);
            if (done_v[0]) begin
                found = 1;
                break;
            end
            #1;
        end
        chk("sllv_junk_found",  found,    1'b1);
        chk("sllv_junk_result", res_v[0], 32'h0000AB00);
        #1;
        funct = 6'b000010; shamt_imm = 5'd4; operand = 32'h000000F0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(0, lat, sb);
        chk("b2b_latency", lat,      5);
        chk("b2b_result",  res_v[0], 32'h0000000F);
        #1;
        wait_idle();

        // Asynchronous reset in the middle of a shift
        funct = 6'b000000; shamt_imm = 5'd20; operand = 32'h00000001; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("busy_before_reset", busy_v, 2'b11);
        reset = 1'b0;
        #1;
        chk("arst_busy",    busy_v,   2'b00);
        chk("arst_done",    done_v,   2'b00);
        chk("arst_illegal", ill_v,    2'b00);
        chk("arst_result0", res_v[0], 32'h0);
        chk("arst_result1", res_v[1], 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_v != 2'b00) dcount++;
        end
        chk("no_done_after_reset", dcount, 0);
        #1;

        // Randomized traffic checked by the model
        for (int i = 0; i < 600; i++) begin
            int sel;
            start = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 7);
            if (sel < 6) funct = legal_f[sel];
            else         funct = bad_f[$urandom_range(0, 3)];
            shamt_imm = 5'($urandom);
            if ($urandom_range(0, 1) == 0) reg_amt = 32'($urandom_range(0, 40));
            else                           reg_amt = $urandom;
            operand = $urandom;
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iterative_shift_unit.md
ITERATIVE_SHIFT_UNIT -- requirements
Module: iterative_shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (≥8, power of two).
REQ-002 SHALL have parameter STEP, default 1, maximum bit positions shifted per cycle (power of two, 1..WIDTH).
REQ-003 SHALL have derived localparam SHW = $clog2(WIDTH), width of a shift amount.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request; sampled only when not busy.
REQ-007 SHALL have port funct  input  6  instruction funct field selecting the operation.
REQ-008 SHALL have port shamt_imm  input  SHW  immediate shift amount (instruction shamt field).
REQ-009 SHALL have port reg_amt  input  WIDTH  variable shift amount source (rs value).
REQ-010 SHALL have port operand  input  WIDTH  value to shift (rt value).
REQ-011 SHALL have port busy  output  1  high while an operation is in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port result  output  WIDTH  shifted value, held from done until next accepted start.
REQ-014 SHALL have port illegal  output  1  high with done when funct was unsupported.

Function
REQ-015 SHALL decode funct: 000000 SLL imm, 000010 SRL imm, 000011 SRA imm, 000100 SLLV reg, 000110 SRLV reg, 000111 SRAV reg.
REQ-016 SHALL use shamt_imm as effective amount for imm ops.
REQ-017 SHALL, for reg ops, use reg_amt[SHW-1:0] when reg_amt < WIDTH, else clamp effective amount to WIDTH-1.
REQ-018 SHALL capture funct-derived op, effective amount and operand on the clk edge where start=1 and state is IDLE or DONE.
REQ-019 SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-020 SHALL transition IDLE/DONE -> SHIFT on accepted start with amount>0; -> DONE on accepted start with amount=0 or unsupported funct; DONE -> IDLE otherwise.
REQ-021 SHALL, in SHIFT, shift the working register by min(STEP, remaining) per cycle and decrement remaining by the same; SHIFT -> DONE when remaining reaches 0.
REQ-022 SHALL fill vacated bits with 0 for SLL/SRL/SLLV/SRLV and with the captured operand MSB for SRA/SRAV.
REQ-023 SHALL assert done exactly in the cycle after the final shift step; start accepted at edge k gives done high in cycle k+1+ceil(amt/STEP) (amt=0: cycle k+1).
REQ-024 SHALL assert busy in SHIFT only; busy=0 in IDLE and DONE.
REQ-025 SHALL ignore start while busy=1 with no effect on state or outputs.
REQ-026 SHALL accept start in the DONE cycle (back-to-back), result updating only at the next done.
REQ-027 SHALL, for unsupported funct, return result=operand with illegal=1 for the done cycle; illegal=0 otherwise.
REQ-028 SHALL keep result stable between done pulses, including during a subsequent SHIFT.

Reset
REQ-029 SHALL on reset=0, immediately and regardless of clk: state IDLE, busy=0, done=0, illegal=0, result=0, internal registers 0.
REQ-030 SHALL abort any in-progress operation on reset with no done pulse; operation restarts only by new start after reset release.

Structure
REQ-031 SHALL place funct encodings (6-bit constants) and the op enum (SLL, SRL, SRA, SLLV, SRLV, SRAV, ILLEGAL) in shared package shift_pkg.
REQ-032 SHALL isolate amount selection/clamp (REQ-016/017) in combinational sub-module shift_amount_sel; FSM and datapath in top.

Verification
REQ-033 WIDTH=32,STEP=1: SLL operand=0x00000001, shamt_imm=4 -> done 5 cycles after start, result=0x00000010.
REQ-034 WIDTH=32,STEP=4: SRAV operand=0x80000000, reg_amt=0x00000100 -> clamped amt 31, done after 9 cycles, result=0xFFFFFFFF.
REQ-035 SRL shamt_imm=0, operand=0xDEADBEEF -> done next cycle, busy never 1, result=0xDEADBEEF.
REQ-036 funct=6'b100000, operand=0x12345678 -> done next cycle, illegal=1, result=0x12345678.
REQ-037 SLLV reg_amt=8 running, assert start with different values mid-SHIFT -> ignored, result=operand<<8; new start in DONE cycle accepted.
REQ-038 Drive reset=0 mid-SHIFT between clk edges -> busy/done/result 0 immediately, no done pulse after release.
